// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-requester arbiter sharing a single memory port between an
//             instruction-side reader and a data-side reader/writer. Requests
//             are granted round-robin when both sides ask at once; the granted
//             operation is latched into registered mem_* outputs and held
//             until the memory responds, after which one IDLE cycle always
//             separates it from the next grant.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             i_read/i_address    - instruction read request and address
//             i_rdata/i_resp      - instruction read data and completion pulse
//             d_read/d_write      - data read / write requests
//             d_byte_enable,
//             d_address, d_wdata  - data write mask, address and write data
//             d_rdata/d_resp      - data read data and completion pulse
//             mem_read/mem_write,
//             mem_byte_enable,
//             mem_address,
//             mem_wdata           - registered shared memory request
//             mem_rdata/mem_resp  - shared memory read data and completion
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  // instruction side
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  // data side
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  // shared memory port
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  // Encoding of the last_grant register.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [3:0] BE_ALL = 4'hF;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        i_req;
  logic        d_req;
  logic        grant_i;
  logic        grant_d;

  // --------------------------------------------------------------------------
  // Request qualification and round-robin choice. When both sides request,
  // the side that did not win last time gets the port; a lone requester
  // always wins. After reset last_grant points at D so I wins the first tie.
  // --------------------------------------------------------------------------
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));
    grant_d = d_req & (~i_req | (last_grant_q == GRANT_I));
  end

  // --------------------------------------------------------------------------
  // Next-state and next-request logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        // mem_resp is deliberately not looked at here: a stray response
        // (e.g. one left over from a transaction killed by reset) is dropped.
        if (grant_i) begin
          state_d      = I_BUSY;
          last_grant_d = GRANT_I;
          mem_read_d   = 1'b1;
          mem_write_d  = 1'b0;
          mem_be_d     = BE_ALL;
          mem_addr_d   = i_address;
          mem_wdata_d  = 32'h0;
        end else if (grant_d) begin
          state_d      = D_BUSY;
          last_grant_d = GRANT_D;
          mem_addr_d   = d_address;
          // A write takes priority over a simultaneous read so the port
          // never carries both strobes at once.
          if (d_write) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b1;
            mem_be_d    = d_byte_enable;
            mem_wdata_d = d_wdata;
          end else begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_be_d    = BE_ALL;
            mem_wdata_d = 32'h0;
          end
        end
      end

      I_BUSY, D_BUSY: begin
        // The latched request is held until the memory answers, regardless
        // of what the requesters do in the meantime. Returning to IDLE
        // (rather than granting again directly) produces the one-cycle
        // bubble between back-to-back transactions.
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and memory request registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Responses are steered combinationally to the side that owns the
  // port; read data is broadcast and only meaningful alongside its resp.
  // --------------------------------------------------------------------------
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_address     = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

  assign i_resp  = (state_q == I_BUSY) & mem_resp;
  assign d_resp  = (state_q == D_BUSY) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Randomized scoreboard bench for mem_arbiter. Requester agents
//             and a memory responder drive the DUT on the falling edge; a
//             reference model predicts each grant from the arbitration rules
//             and queues the expected memory request; a monitor pops and
//             checks requests, hold stability, response steering and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_address       (i_address),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byte_enable   (d_byte_enable),
    .d_address       (d_address),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected memory request for one granted transaction.
  typedef struct packed {
    logic        side_d;     // 0 = instruction side, 1 = data side
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;  // write data is only defined for I and D writes
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // stimulus knobs
  int p_req      = 0;   // percent chance per cycle an idle agent requests
  int p_wd       = 0;   // percent chance per cycle a pending agent withdraws
  int spur_en    = 0;   // stray mem_resp pulses while the port is idle
  int mem_max_dl = 3;   // maximum memory response delay in cycles

  // --------------------------------------------------------------------------
  // Instruction-side agent: holds i_read until it sees i_resp.
  // --------------------------------------------------------------------------
  logic i_pend = 1'b0;
  logic i_done = 1'b0;
  always begin
    @(negedge clk);
    if (i_done) begin
      i_read = 1'b0;
      i_pend = 1'b0;
    end
    if (!i_pend) begin
      if ($urandom_range(0, 99) < p_req) begin
        i_read    = 1'b1;
        i_address = {$urandom_range(0, 32'h3FFF), 2'b00};
        i_pend    = 1'b1;
      end
    end else if ($urandom_range(0, 99) < p_wd) begin
      i_read = 1'b0;
      i_pend = 1'b0;
    end
    #2;
    i_done = i_pend && i_resp;
  end

  // --------------------------------------------------------------------------
  // Data-side agent: random read / write / read+write requests.
  // --------------------------------------------------------------------------
  logic d_pend = 1'b0;
  logic d_done = 1'b0;
  always begin
    @(negedge clk);
    if (d_done) begin
      d_read  = 1'b0;
      d_write = 1'b0;
      d_pend  = 1'b0;
    end
    if (!d_pend) begin
      if ($urandom_range(0, 99) < p_req) begin
        case ($urandom_range(0, 2))
          0:       begin d_read = 1'b1; d_write = 1'b0; end
          1:       begin d_read = 1'b0; d_write = 1'b1; end
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_address     = $urandom;
        d_wdata       = $urandom;
        d_byte_enable = 4'($urandom_range(0, 15));
        d_pend        = 1'b1;
      end
    end else if ($urandom_range(0, 99) < p_wd) begin
      d_read  = 1'b0;
      d_write = 1'b0;
      d_pend  = 1'b0;
    end
    #2;
    d_done = d_pend && d_resp;
  end

  // --------------------------------------------------------------------------
  // Memory responder. Once it sees a request it answers after a random delay,
  // even if the request vanishes meanwhile (reset), which produces stale
  // responses the arbiter has to tolerate.
  // --------------------------------------------------------------------------
  logic m_pend = 1'b0;
  int   m_cnt  = 0;
  always begin
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = $urandom;
    if (!m_pend && (mem_read || mem_write)) begin
      m_pend = 1'b1;
      m_cnt  = $urandom_range(0, mem_max_dl);
    end
    if (m_pend) begin
      if (m_cnt == 0) begin
        mem_resp = 1'b1;
        m_pend   = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else if (spur_en != 0 && !mem_read && !mem_write &&
                 $urandom_range(0, 7) == 0) begin
      mem_resp = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: whenever the port is free and someone is asking, the
  // grant goes to the lone requester, or on a tie to the side that did not
  // win last. The port is free again the cycle after a response.
  // --------------------------------------------------------------------------
  logic m_busy = 1'b0;
  logic m_last = 1'b1;
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (m_busy) begin
      if (mem_resp) m_busy = 1'b0;
    end else begin
      automatic logic ri   = i_read;
      automatic logic rd   = d_read | d_write;
      automatic logic side;
      automatic exp_t e;
      if (ri || rd) begin
        side = (ri && rd) ? ~m_last : rd;
        e.side_d = side;
        if (!side) begin
          e.rd = 1'b1; e.wr = 1'b0; e.be = 4'hF;
          e.addr = i_address; e.wdata = 32'h0; e.chk_wdata = 1'b1;
        end else if (d_write) begin
          e.rd = 1'b0; e.wr = 1'b1; e.be = d_byte_enable;
          e.addr = d_address; e.wdata = d_wdata; e.chk_wdata = 1'b1;
        end else begin
          e.rd = 1'b1; e.wr = 1'b0; e.be = 4'hF;
          e.addr = d_address; e.wdata = 32'h0; e.chk_wdata = 1'b0;
        end
        exp_q.push_back(e);
        m_busy = 1'b1;
        m_last = side;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: samples 2 ns after the falling edge, well away from the rising
  // edge, and checks everything the DUT presents against the scoreboard.
  // --------------------------------------------------------------------------
  exp_t cur;
  logic cur_valid = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      n_vec++;
      if (mem_read || mem_write || i_resp || d_resp || mem_byte_enable != 4'h0 ||
          mem_address != 32'h0 || mem_wdata != 32'h0) begin
        n_err++;
        $display("FAIL reset_state @%0t: rd=%b wr=%b be=%h addr=%h wd=%h iresp=%b dresp=%b, required all zero",
                 $time, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp, d_resp);
      end
      exp_q.delete();
      cur_valid = 1'b0;
    end else begin
      if (!cur_valid && exp_q.size() > 0) begin
        cur       = exp_q.pop_front();
        cur_valid = 1'b1;
      end
      if (cur_valid) begin
        automatic logic [31:0] wd_cmp = cur.chk_wdata ? mem_wdata : cur.wdata;
        n_vec++;
        if (mem_read !== cur.rd || mem_write !== cur.wr || mem_byte_enable !== cur.be ||
            mem_address !== cur.addr || wd_cmp !== cur.wdata) begin
          n_err++;
          $display("FAIL mem_request @%0t: got rd=%b wr=%b be=%h addr=%h wd=%h, required rd=%b wr=%b be=%h addr=%h wd=%h",
                   $time, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
                   cur.rd, cur.wr, cur.be, cur.addr, cur.wdata);
        end
        n_vec++;
        if (i_resp !== (mem_resp && !cur.side_d) || d_resp !== (mem_resp && cur.side_d)) begin
          n_err++;
          $display("FAIL resp_steer @%0t: got iresp=%b dresp=%b, required iresp=%b dresp=%b",
                   $time, i_resp, d_resp, mem_resp && !cur.side_d, mem_resp && cur.side_d);
        end
        if (mem_resp) cur_valid = 1'b0;
      end else begin
        n_vec++;
        if (mem_read || mem_write || i_resp || d_resp) begin
          n_err++;
          $display("FAIL idle_port @%0t: got rd=%b wr=%b iresp=%b dresp=%b (mem_resp=%b), required all zero",
                   $time, mem_read, mem_write, i_resp, d_resp, mem_resp);
        end
      end
      n_vec++;
      if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin
        n_err++;
        $display("FAIL rdata_pass @%0t: got i_rdata=%h d_rdata=%h, required %h",
                 $time, i_rdata, d_rdata, mem_rdata);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Main sequence.
  // --------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    i_read        = 1'b0;
    i_address     = 32'h0;
    d_read        = 1'b0;
    d_write       = 1'b0;
    d_byte_enable = 4'h0;
    d_address     = 32'h0;
    d_wdata       = 32'h0;
    mem_rdata     = 32'h0;
    mem_resp      = 1'b0;

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Both sides requesting back to back: alternating grants starting with I.
    p_req = 100;
    repeat (40) @(negedge clk);

    // General random traffic with withdrawals and stray responses.
    p_req   = 30;
    p_wd    = 3;
    spur_en = 1;
    repeat (2000) @(negedge clk);

    // Resets in the middle of transactions, with long memory delays so the
    // killed transaction's response often lands after reset.
    p_req      = 60;
    p_wd       = 0;
    mem_max_dl = 6;
    for (int k = 0; k < 8; k++) begin
      automatic bit seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (mem_read || mem_write) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
        n_err++;
        $display("FAIL wait_busy: no memory request within 50 cycles, required one");
      end else begin
        #1 rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        #1 rst = 1'b0;
      end
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    // Drain.
    p_req   = 0;
    spur_en = 0;
    repeat (40) @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
